// File: rtl/uart_pkg.sv
// Shared constants for the 8N1 UART: default baud divisor, frame levels
// and the state encoding used by both the TX and RX state machines.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DFLT = 10417;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  localparam int unsigned STATE_W  = 2;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_START = 2'd1;
  localparam logic [1:0]  ST_DATA  = 2'd2;
  localparam logic [1:0]  ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for bit timing. tc_o is high while the count sits
// at zero; half_i selects a half-bit load so RX can land on the bit centre.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic half_i,
  output logic tc_o
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = half_i ? HALF_LOAD : FULL_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // tc is registered alongside the count so it always equals (cnt_q == 0)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == '0);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/uart_ctrl.sv
// Full-duplex 8N1 UART: independent TX serialiser and RX deserialiser
// sharing clock and reset, each timed by its own uart_bit_timer.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int unsigned DATA_BITS    = uart_pkg::DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] send_data,
  output logic                 ready,
  output logic                 UART_TX,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 vald_data
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  // ---------------------------------------------------------------- TX
  logic [STATE_W-1:0]   tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 tx_load;
  logic                 tx_tc;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (tx_load),
    .half_i (1'b0),
    .tc_o   (tx_tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_q <= ST_IDLE;
      tx_data_q  <= '0;
      tx_idx_q   <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tx_idx_q   <= tx_idx_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
    end
  end

  // Each level is driven one edge early so UART_TX stays a pure register
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_idx_d   = tx_idx_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        if (send) begin
          tx_data_d  = send_data;
          tx_d       = START_BIT;
          ready_d    = 1'b0;
          tx_load    = 1'b1;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_tc) begin
          tx_d       = tx_data_q[0];
          tx_idx_d   = '0;
          tx_load    = 1'b1;
          tx_state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_tc) begin
          tx_load = 1'b1;
          if (tx_idx_q == IDX_W'(DATA_BITS - 1)) begin
            tx_d       = STOP_BIT;
            tx_state_d = ST_STOP;
          end else begin
            tx_d     = tx_data_q[tx_idx_q + IDX_W'(1)];
            tx_idx_d = tx_idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tx_tc) begin
          ready_d    = 1'b1;
          tx_state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d       = 1'b1;
        ready_d    = 1'b1;
        tx_state_d = ST_IDLE;
      end
    endcase
  end

  assign UART_TX = tx_q;
  assign ready   = ready_q;

  // ---------------------------------------------------------------- RX
  logic [STATE_W-1:0]   rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic                 vald_q, vald_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 rx_load;
  logic                 rx_half;
  logic                 rx_tc;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (rx_load),
    .half_i (rx_half),
    .tc_o   (rx_tc)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state_q <= ST_IDLE;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_idx_q   <= '0;
      vald_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_idx_q   <= rx_idx_d;
      vald_q     <= vald_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_idx_d   = rx_idx_q;
    vald_d     = 1'b0;
    ferr_d     = ferr_q;
    rx_load    = 1'b0;
    rx_half    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_load    = 1'b1;
          rx_half    = 1'b1;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_tc) begin
          if (rx_sync_q == START_BIT) begin
            rx_load    = 1'b1;
            rx_idx_d   = '0;
            rx_state_d = ST_DATA;
          end else begin
            rx_state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (rx_tc) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_load    = 1'b1;
          if (rx_idx_q == IDX_W'(DATA_BITS - 1)) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        // After a framing error, hold here until the line idles high
        if (ferr_q) begin
          if (rx_sync_q) begin
            ferr_d     = 1'b0;
            rx_state_d = ST_IDLE;
          end
        end else if (rx_tc) begin
          if (rx_sync_q == STOP_BIT) begin
            rx_data_d  = rx_shift_q;
            vald_d     = 1'b1;
            rx_state_d = ST_IDLE;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        ferr_d     = 1'b0;
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  assign recv_data = rx_data_q;
  assign vald_data = vald_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl at 16 clocks per bit: TX waveform, busy
// ignore, loopback RX, glitch / framing-error rejection and mid-frame reset.
module tb_uart_ctrl;

  localparam int unsigned CPB = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       send;
  logic [7:0] send_data;
  logic       ready;
  logic       UART_TX;
  logic       UART_RX;
  logic [7:0] recv_data;
  logic       vald_data;

  logic       loopback;
  logic       rx_drv;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] rx_q[$];
  logic       vald_prev  = 1'b0;
  logic       pulse_long = 1'b0;

  assign UART_RX = loopback ? UART_TX : rx_drv;

  uart_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .send      (send),
    .send_data (send_data),
    .ready     (ready),
    .UART_TX   (UART_TX),
    .UART_RX   (UART_RX),
    .recv_data (recv_data),
    .vald_data (vald_data)
  );

  always #5 CLK = ~CLK;

  // Collect every received byte and flag any pulse wider than one cycle
  always @(negedge CLK) begin
    if (vald_data) begin
      rx_q.push_back(recv_data);
      if (vald_prev) pulse_long = 1'b1;
    end
    vald_prev = vald_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just after the accepting edge; walks all 160 cycles
  task automatic check_tx_frame(input string tag, input logic [9:0] frame, input bit poke);
    int lvl_ok;
    int rdy_low = 0;
    for (int k = 0; k < 10; k++) begin
      lvl_ok = 0;
      for (int c = 0; c < int'(CPB); c++) begin
        if (UART_TX === frame[k]) lvl_ok++;
        if (ready === 1'b0) rdy_low++;
        if (poke && k == 2 && c == 8) begin
          send      = 1'b1;
          send_data = 8'h55;
        end else begin
          send = 1'b0;
        end
        @(negedge CLK);
      end
      check_eq($sformatf("%s_bit%0d", tag, k), lvl_ok, CPB);
    end
    check_eq({tag, "_ready_low_cycles"}, rdy_low, 160);
    check_eq({tag, "_ready_back"}, ready, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send      = 1'b1;
    send_data = b;
    @(negedge CLK);
    send = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check_eq({tag, "_ready_wait"}, ready, 1);
  endtask

  task automatic drive_rx_frame(input logic [9:0] bits);
    for (int k = 0; k < 10; k++) begin
      rx_drv = bits[k];
      repeat (CPB) @(negedge CLK);
    end
    rx_drv = 1'b1;
  endtask

  task automatic check_idle_span(input string tag, input int cycles);
    int tx_hi = 0;
    int rdy_hi = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      if (UART_TX === 1'b1) tx_hi++;
      if (ready === 1'b1) rdy_hi++;
    end
    check_eq({tag, "_tx_high_cycles"}, tx_hi, cycles);
    check_eq({tag, "_ready_high_cycles"}, rdy_hi, cycles);
  endtask

  initial begin
    RST       = 1'b1;
    send      = 1'b0;
    send_data = 8'h00;
    loopback  = 1'b0;
    rx_drv    = 1'b1;

    // Reset and idle
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_tx", UART_TX, 1);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_vald", vald_data, 0);
    check_eq("rst_recv", recv_data, 8'h00);
    RST = 1'b0;
    check_idle_span("idle", 20);
    check_eq("idle_vald", rx_q.size(), 0);

    // TX 0x41 with a 0x55 request while busy: frame 1_01000001_0
    send      = 1'b1;
    send_data = 8'h41;
    @(negedge CLK);
    check_tx_frame("tx41", 10'b1_0100_0001_0, 1'b1);
    check_idle_span("busy_ignore", 40);

    // Loopback: 0x0D then 0xFF back-to-back
    loopback = 1'b1;
    rx_q.delete();
    pulse_long = 1'b0;
    send_byte(8'h0D);
    wait_ready("lb0");
    send_byte(8'hFF);
    wait_ready("lb1");
    repeat (40) @(negedge CLK);
    check_eq("lb_count", rx_q.size(), 2);
    check_eq("lb_byte0", rx_q[0], 8'h0D);
    check_eq("lb_byte1", rx_q[1], 8'hFF);
    check_eq("lb_pulse_single", pulse_long, 0);
    check_eq("lb_recv_hold", recv_data, 8'hFF);
    loopback = 1'b0;
    rx_q.delete();

    // Short glitch must not start a frame
    repeat (10) @(negedge CLK);
    rx_drv = 1'b0;
    repeat (4) @(negedge CLK);
    rx_drv = 1'b1;
    repeat (40) @(negedge CLK);
    check_eq("glitch_no_vald", rx_q.size(), 0);

    // 0xA5 with stop bit 0, line held low a further bit then released
    drive_rx_frame({1'b0, 8'hA5, 1'b0});
    rx_drv = 1'b0;
    repeat (CPB) @(negedge CLK);
    rx_drv = 1'b1;
    repeat (40) @(negedge CLK);
    check_eq("ferr_no_vald", rx_q.size(), 0);
    check_eq("ferr_recv_unchanged", recv_data, 8'hFF);

    // Good frame after the framing error
    drive_rx_frame({1'b1, 8'h3C, 1'b0});
    repeat (20) @(negedge CLK);
    check_eq("good_count", rx_q.size(), 1);
    check_eq("good_byte", rx_q[0], 8'h3C);
    check_eq("good_recv", recv_data, 8'h3C);
    check_eq("good_pulse_single", pulse_long, 0);

    // Reset 50 cycles into a 0x00 frame
    send_byte(8'h00);
    repeat (49) @(negedge CLK);
    check_eq("midtx_busy", ready, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_eq("midtx_rst_tx", UART_TX, 1);
    check_eq("midtx_rst_ready", ready, 1);
    check_idle_span("midtx_after", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
